// File: rtl/fir_pkg.sv
// Shared types, default coefficients and Q-format multiply for the FM radio FIR stages.
// Reused by the decimating and interpolating filters.
package fir_pkg;

  typedef enum logic [1:0] {
    READ,
    RUN,
    WRITE
  } state_t;

  localparam int DEF_TAPS = 32;

  // Symmetric Q10 lowpass; element order is irrelevant because h[i] == h[31-i].
  localparam logic [DEF_TAPS-1:0][31:0] DEF_COEFF = {
    32'(-3),  32'(-5),  32'(-6),  32'(-4),  32'(2),   32'(12),  32'(22),  32'(26),
    32'(18),  32'(-2),  32'(-28), 32'(-46), 32'(-40), 32'(4),   32'(90),  32'(200),
    32'(200), 32'(90),  32'(4),   32'(-40), 32'(-46), 32'(-28), 32'(-2),  32'(18),
    32'(26),  32'(22),  32'(12),  32'(2),   32'(-4),  32'(-6),  32'(-5),  32'(-3)
  };

  // Full-precision signed product scaled back to the Q format; the caller keeps the low bits.
  function automatic logic signed [63:0] mul_q(input logic signed [63:0] a,
                                               input logic signed [63:0] b,
                                               input int                 frac);
    logic signed [63:0] prod;
    prod = a * b;
    return prod >>> frac;
  endfunction

endpackage

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input pop produces INTERP filtered outputs,
// each computed with TAP_NUMBER/INTERP single-MAC cycles.
module fir_interp
  import fir_pkg::*;
#(
  parameter int                            TAP_NUMBER = 32,
  parameter int                            INTERP     = 4,
  parameter int                            DATA_WIDTH = 32,
  parameter int                            FRAC_BITS  = 10,
  parameter int                            GAIN_SHIFT = 2,
  parameter logic [TAP_NUMBER-1:0][31:0]   CONV_COEFF = DEF_COEFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_wr_en,
  input  logic                  out_full
);

  localparam int TPP = TAP_NUMBER / INTERP;
  localparam int KW  = (TPP > 1) ? $clog2(TPP) : 1;
  localparam int PW  = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int IW  = (TAP_NUMBER > 1) ? $clog2(TAP_NUMBER) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(TPP - 1);
  localparam logic [PW-1:0] P_LAST = PW'(INTERP - 1);

  state_t                       state_q;
  logic [PW-1:0]                phase_q;
  logic [KW-1:0]                k_q;
  logic signed [DATA_WIDTH-1:0] acc_q;
  logic signed [DATA_WIDTH-1:0] acc_d;
  logic signed [DATA_WIDTH-1:0] x_q [TPP];

  logic [IW-1:0]                coef_idx;
  logic signed [63:0]           coef_w;
  logic signed [63:0]           samp_w;
  logic signed [63:0]           prod_w;

  // Phase p of sample n uses taps p, p+L, p+2L, ... against x[0], x[1], x[2], ...
  always_comb begin
    coef_idx = IW'(int'(phase_q) + int'(k_q) * INTERP);
    coef_w   = 64'(signed'(CONV_COEFF[coef_idx]));
    samp_w   = 64'(x_q[k_q]);
    prod_w   = mul_q(coef_w, samp_w, FRAC_BITS);
    acc_d    = acc_q + DATA_WIDTH'(prod_w);
  end

  assign in_rd_en  = (state_q == READ) && !in_empty;
  assign out_wr_en = (state_q == WRITE) && !out_full;
  assign out_din   = out_wr_en ? DATA_WIDTH'(acc_q <<< GAIN_SHIFT) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= READ;
      phase_q <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      for (int i = 0; i < TPP; i++) x_q[i] <= '0;
    end else begin
      case (state_q)
        READ: begin
          if (!in_empty) begin
            x_q[0] <= signed'(in_dout);
            for (int i = 1; i < TPP; i++) x_q[i] <= x_q[i-1];
            phase_q <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= WRITE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        WRITE: begin
          // A full downstream FIFO freezes acc and phase so a stall cannot alter the result.
          if (!out_full) begin
            acc_q <= '0;
            if (phase_q == P_LAST) begin
              state_q <= READ;
            end else begin
              phase_q <= phase_q + PW'(1);
              state_q <= RUN;
            end
          end
        end
        default: state_q <= READ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Bench for fir_interp: two instances (gain shift 0 and 2) share one FIFO model and are
// compared every cycle against a direct-convolution model of the interpolator.
module tb_fir_interp;
  import fir_pkg::*;

  localparam int L   = 4;
  localparam int TPP = 8;
  localparam int FB  = 10;
  localparam int BUDGET = 3000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_dout;
  logic        in_empty;
  logic        out_full;
  logic        rd0, wr0, rd2, wr2;
  logic [31:0] din0, din2;

  fir_interp #(.GAIN_SHIFT(0)) dut_g0 (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(rd0), .out_din(din0), .out_wr_en(wr0), .out_full(out_full)
  );

  fir_interp dut_g2 (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(rd2), .out_din(din2), .out_wr_en(wr2), .out_full(out_full)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   rd_count = 0;
  int   wr_count = 0;
  int   src_q[$];
  logic pop_pending = 1'b0;
  int   hist[TPP];
  int   exp0[$];
  int   exp2[$];
  int   log0[$];
  int   log2[$];
  int   rd_cyc[$];

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act == want) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  function automatic int coef(input int i);
    return int'($signed(DEF_COEFF[i]));
  endfunction

  function automatic int mulq(input int h, input int x);
    longint p;
    p = longint'(h) * longint'(x);
    p = p >>> FB;
    return int'(p[31:0]);
  endfunction

  // y[nL+p] = sum_k mul_q(h[p+kL], x[n-k]); 32-bit wrapping sum.
  task automatic model_pop(input int v);
    logic [31:0] s;
    for (int k = TPP - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    for (int p = 0; p < L; p++) begin
      s = 32'd0;
      for (int k = 0; k < TPP; k++) s = s + 32'(mulq(coef(p + k * L), hist[k]));
      exp0.push_back(int'(s));
      exp2.push_back(int'(s << 2));
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      foreach (hist[i]) hist[i] = 0;
      exp0.delete();
      exp2.delete();
    end else begin
      chk("rd_wr_exclusive", int'(rd2 & wr2), 0);
      chk("instances_agree", int'({rd0, wr0}), int'({rd2, wr2}));
      if (!wr2) chk("din_idle_zero", int'(din2 | din0), 0);
      if (rd2) begin
        chk("rd_only_when_avail", int'(in_empty), 0);
        model_pop(int'(in_dout));
        pop_pending = 1'b1;
        rd_count++;
        rd_cyc.push_back(cyc);
      end
      if (wr2) begin
        wr_count++;
        log0.push_back(int'(din0));
        log2.push_back(int'(din2));
        if (exp2.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("out_din_g0", int'(din0), exp0.pop_front());
          chk("out_din_g2", int'(din2), exp2.pop_front());
        end
      end
    end
  end

  // First-word-fall-through upstream FIFO.
  initial begin
    in_empty = 1'b1;
    in_dout  = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (pop_pending) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        pop_pending = 1'b0;
      end
      in_empty = (src_q.size() == 0);
      in_dout  = in_empty ? 32'd0 : 32'(src_q[0]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((src_q.size() != 0 || pop_pending || exp2.size() != 0) && n < BUDGET) begin
      tick();
      n++;
    end
    chk(name, int'(n >= BUDGET), 0);
  endtask

  task automatic wait_wr(input int target, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < BUDGET) begin
      tick();
      n++;
    end
    chk(name, int'(n >= BUDGET), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base, r0, w0, b;
    reset    = 1'b1;
    out_full = 1'b0;
    #3;
    chk("reset_rd_en", int'(rd2), 0);
    chk("reset_wr_en", int'(wr2), 0);
    chk("reset_out_din", int'(din2), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Impulse: 32 outputs reproduce h[0..31]
    base = log0.size();
    src_q.push_back(1024);
    repeat (7) src_q.push_back(0);
    drain("impulse_timeout");
    chk("impulse_count", log0.size() - base, 32);
    chk("impulse_h0", log0[base], -3);
    chk("impulse_h1", log0[base+1], -5);
    chk("impulse_h15", log0[base+15], 200);
    chk("impulse_h31", log0[base+31], -3);

    // Negative impulse
    base = log0.size();
    src_q.push_back(-1024);
    repeat (7) src_q.push_back(0);
    drain("neg_impulse_timeout");
    chk("neg_h0", log0[base], 3);
    chk("neg_h1", log0[base+1], 5);
    chk("neg_h2", log0[base+2], 6);
    chk("neg_h3", log0[base+3], 4);
    chk("neg_h0_gain", log2[base], 12);

    // DC with default gain
    base = log2.size();
    repeat (20) src_q.push_back(1024);
    drain("dc_timeout");
    chk("dc_p0", log2[base+76], 612);
    chk("dc_p1", log2[base+77], 348);
    chk("dc_p2", log2[base+78], 348);
    chk("dc_p3", log2[base+79], 612);

    // Backpressure during the phase-1 WRITE of sample 500
    base = log2.size();
    w0 = wr_count;
    repeat (7) src_q.push_back(0);
    src_q.push_back(500);
    wait_wr(w0 + 29, "bp_wait_timeout");
    repeat (4) tick();
    r0 = rd_count;
    w0 = wr_count;
    out_full = 1'b1;
    repeat (50) tick();
    chk("stall_no_write", wr_count - w0, 0);
    chk("stall_no_read", rd_count - r0, 0);
    out_full = 1'b0;
    drain("bp_drain_timeout");
    chk("bp_p0_value", log2[base+28], -8);
    chk("bp_p1_value", log2[base+29], -12);

    // Starvation, then three inputs
    r0 = rd_count;
    w0 = wr_count;
    repeat (100) tick();
    chk("starve_no_read", rd_count - r0, 0);
    chk("starve_no_write", wr_count - w0, 0);
    b = rd_cyc.size();
    src_q.push_back(100);
    src_q.push_back(200);
    src_q.push_back(-300);
    drain("three_timeout");
    chk("three_reads", rd_count - r0, 3);
    chk("three_writes", wr_count - w0, 12);
    chk("read_spacing_1", rd_cyc[b+1] - rd_cyc[b], 37);
    chk("read_spacing_2", rd_cyc[b+2] - rd_cyc[b+1], 37);

    // Reset during RUN of phase 2
    w0 = wr_count;
    repeat (7) src_q.push_back(0);
    src_q.push_back(2000);
    wait_wr(w0 + 30, "rst_wait_timeout");
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("midrun_reset_rd", int'(rd2), 0);
    chk("midrun_reset_wr", int'(wr2), 0);
    chk("midrun_reset_din", int'(din2), 0);
    src_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    base = log0.size();
    src_q.push_back(1024);
    wait_wr(wr_count + 4, "post_rst_timeout");
    chk("post_rst_h0", log0[base], -3);
    chk("post_rst_h1", log0[base+1], -5);
    chk("post_rst_h2", log0[base+2], -6);
    chk("post_rst_h3", log0[base+3], -4);
    repeat (7) src_q.push_back(0);
    drain("post_rst_drain_timeout");
    chk("post_rst_h4", log0[base+4], 2);
    chk("all_outputs_written", exp2.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
